// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD window-fill engine: panel opcodes, pixel
// format encodings, bytes-per-pixel constants, the fill FSM state type and a
// helper that picks the bytes of a CASET/PASET sequence.
package lcd_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam int unsigned PIX_MODE_RGB565 = 0;
  localparam int unsigned PIX_MODE_RGB666 = 1;

  localparam int unsigned BPP_RGB565 = 2;
  localparam int unsigned BPP_RGB666 = 3;

  // Wide enough for a 1024x1024 window, the largest the 10-bit bounds allow.
  localparam int unsigned PIX_CNT_W = 22;

  typedef enum logic [2:0] {
    StIdle,
    StCaset,
    StPaset,
    StRamwr,
    StPixels,
    StDone
  } lcd_state_e;

  function automatic int unsigned bytes_per_pixel(input int unsigned mode);
    return (mode == PIX_MODE_RGB565) ? BPP_RGB565 : BPP_RGB666;
  endfunction

  // Byte idx of an address-set sequence: command, lo[9:8], lo[7:0], hi[9:8], hi[7:0].
  function automatic logic [7:0] window_byte(input logic [7:0] cmd, input logic [9:0] lo,
                                             input logic [9:0] hi, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = cmd;
      3'd1:    b = {6'b000000, lo[9:8]};
      3'd2:    b = lo[7:0];
      3'd3:    b = {6'b000000, hi[9:8]};
      default: b = hi[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lcd_pixel_serializer.sv
// Maps an RGB565 fill colour and a byte index within the pixel to the byte
// sent on the panel bus.
//   color    in  16  RGB565 colour
//   byte_idx in  2   byte position within the pixel (0 = first)
//   pix_byte out 8   byte to transfer
// RGB565 sends the colour as-is (2 bytes); RGB666 sends one left-aligned byte
// per channel (3 bytes).
module lcd_pixel_serializer
  import lcd_pkg::*;
#(
  parameter int unsigned PIX_MODE = PIX_MODE_RGB666
) (
  input  logic [15:0] color,
  input  logic [1:0]  byte_idx,
  output logic [7:0]  pix_byte
);

  localparam bit IsRgb565 = (PIX_MODE == PIX_MODE_RGB565);

  always_comb begin
    pix_byte = 8'h00;
    case (byte_idx)
      2'd0:    pix_byte = IsRgb565 ? color[15:8] : {color[15:11], 3'b000};
      2'd1:    pix_byte = IsRgb565 ? color[7:0] : {color[10:5], 2'b00};
      2'd2:    pix_byte = IsRgb565 ? 8'h00 : {color[4:0], 3'b000};
      default: pix_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/lcd_window_fill.sv
// Fills a rectangular panel window with one colour: sends CASET, PASET and
// RAMWR with their parameters, then streams the pixel bytes, all over a
// valid/ready byte bus.
//   clk, reset_states     clock, asynchronous active-high reset
//   start                 one-cycle fill request (sampled only when idle)
//   x0, x1, y0, y1        inclusive window bounds
//   color                 RGB565 fill colour
//   bus_ready             sink accepts data_out this cycle
//   data_out/data_valid   byte and its valid flag, held while bus_ready=0
//   data_command          0 = command byte, 1 = data byte
//   disp_cs               chip select, active-low
//   busy                  fill in progress
//   fill_done             one-cycle completion pulse
//   win_err               one-cycle pulse for a rejected (out-of-range) window
module lcd_window_fill
  import lcd_pkg::*;
#(
  parameter int unsigned H_RES    = 320,
  parameter int unsigned V_RES    = 480,
  parameter int unsigned PIX_MODE = PIX_MODE_RGB666
) (
  input  logic        clk,
  input  logic        reset_states,
  input  logic        start,
  input  logic [9:0]  x0,
  input  logic [9:0]  x1,
  input  logic [9:0]  y0,
  input  logic [9:0]  y1,
  input  logic [15:0] color,
  input  logic        bus_ready,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        data_command,
  output logic        disp_cs,
  output logic        busy,
  output logic        fill_done,
  output logic        win_err
);

  localparam logic [10:0] HResLim     = 11'(H_RES);
  localparam logic [10:0] VResLim     = 11'(V_RES);
  localparam logic [2:0]  LastPixByte = 3'(bytes_per_pixel(PIX_MODE) - 1);

  lcd_state_e           state_q, state_d;
  logic [2:0]           byte_idx_q, byte_idx_d;
  logic [PIX_CNT_W-1:0] pix_cnt_q, pix_cnt_d, pix_total;
  logic [9:0]           x0_q, x1_q, y0_q, y1_q;
  logic [15:0]          color_q;
  logic                 win_err_q;
  logic                 win_ok, idle_start, accept, xfer;
  logic [10:0]          width, height;
  logic [7:0]           pix_byte;

  assign win_ok = (x0 <= x1) && (y0 <= y1) && ({1'b0, x1} < HResLim) && ({1'b0, y1} < VResLim);
  assign idle_start = (state_q == StIdle) && start;
  assign accept     = idle_start && win_ok;

  assign width     = {1'b0, x1_q} - {1'b0, x0_q} + 11'd1;
  assign height    = {1'b0, y1_q} - {1'b0, y0_q} + 11'd1;
  assign pix_total = PIX_CNT_W'(width) * PIX_CNT_W'(height);

  assign xfer    = data_valid && bus_ready;
  assign win_err = win_err_q;

  lcd_pixel_serializer #(
    .PIX_MODE (PIX_MODE)
  ) u_serializer (
    .color    (color_q),
    .byte_idx (byte_idx_q[1:0]),
    .pix_byte (pix_byte)
  );

  // Bus outputs decode straight from registered state so they hold during stalls
  // and drop the instant reset is applied.
  always_comb begin
    data_out     = 8'h00;
    data_valid   = 1'b0;
    data_command = 1'b0;
    disp_cs      = 1'b1;
    busy         = 1'b0;
    fill_done    = 1'b0;
    case (state_q)
      StCaset: begin
        data_valid   = 1'b1;
        disp_cs      = 1'b0;
        busy         = 1'b1;
        data_command = (byte_idx_q != 3'd0);
        data_out     = window_byte(CMD_CASET, x0_q, x1_q, byte_idx_q);
      end
      StPaset: begin
        data_valid   = 1'b1;
        disp_cs      = 1'b0;
        busy         = 1'b1;
        data_command = (byte_idx_q != 3'd0);
        data_out     = window_byte(CMD_PASET, y0_q, y1_q, byte_idx_q);
      end
      StRamwr: begin
        data_valid = 1'b1;
        disp_cs    = 1'b0;
        busy       = 1'b1;
        data_out   = CMD_RAMWR;
      end
      StPixels: begin
        data_valid   = 1'b1;
        disp_cs      = 1'b0;
        busy         = 1'b1;
        data_command = 1'b1;
        data_out     = pix_byte;
      end
      StDone:  fill_done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    pix_cnt_d  = pix_cnt_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d    = StCaset;
          byte_idx_d = 3'd0;
        end
      end
      StCaset: begin
        if (xfer) begin
          if (byte_idx_q == 3'd4) begin
            state_d    = StPaset;
            byte_idx_d = 3'd0;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
          end
        end
      end
      StPaset: begin
        if (xfer) begin
          if (byte_idx_q == 3'd4) begin
            state_d    = StRamwr;
            byte_idx_d = 3'd0;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
          end
        end
      end
      StRamwr: begin
        if (xfer) begin
          state_d    = StPixels;
          byte_idx_d = 3'd0;
          pix_cnt_d  = pix_total;
        end
      end
      StPixels: begin
        if (xfer) begin
          if (byte_idx_q == LastPixByte) begin
            byte_idx_d = 3'd0;
            pix_cnt_d  = pix_cnt_q - PIX_CNT_W'(1);
            if (pix_cnt_q == PIX_CNT_W'(1)) begin
              state_d = StDone;
            end
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset_states) begin
    if (reset_states) begin
      state_q    <= StIdle;
      byte_idx_q <= 3'd0;
      pix_cnt_q  <= '0;
      x0_q       <= 10'd0;
      x1_q       <= 10'd0;
      y0_q       <= 10'd0;
      y1_q       <= 10'd0;
      color_q    <= 16'h0000;
      win_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      pix_cnt_q  <= pix_cnt_d;
      win_err_q  <= idle_start && !win_ok;
      if (accept) begin
        x0_q    <= x0;
        x1_q    <= x1;
        y0_q    <= y0;
        y1_q    <= y1;
        color_q <= color;
      end
    end
  end

endmodule

// File: tb/tb_lcd_window_fill.sv
// Drives an RGB565 instance (index 0) and an RGB666 instance (index 1) with the
// same stimulus and compares their byte streams against a byte-list model.
module tb_lcd_window_fill;

  logic            clk = 1'b0;
  logic            reset_states, start, bus_ready;
  logic [9:0]      x0, x1, y0, y1;
  logic [15:0]     color;
  logic [1:0][7:0] data_out;
  logic [1:0]      data_valid, data_command, disp_cs, busy, fill_done, win_err;

  int vectors = 0;
  int miscompares = 0;

  // Monitor state (written only by the monitor process)
  logic [8:0] cap_q [2][$];
  int done_cnt [2] = '{0, 0};
  int err_cnt [2] = '{0, 0};
  int csx_cnt [2] = '{0, 0};
  int cslow_cnt [2] = '{0, 0};
  int stall_checks = 0;
  int stall_bad = 0;
  bit prev_stall [2] = '{1'b0, 1'b0};
  logic [8:0] prev_byte [2];

  // Per-test baselines and expected streams (written only by the stimulus)
  logic [8:0] exp_q [2][$];
  int cap_base [2], done_base [2], err_base [2], csx_base [2], cslow_base [2];

  always #5 clk = ~clk;

  lcd_window_fill #(.H_RES(320), .V_RES(480), .PIX_MODE(0)) u_dut565 (
    .clk(clk), .reset_states(reset_states), .start(start),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color), .bus_ready(bus_ready),
    .data_out(data_out[0]), .data_valid(data_valid[0]), .data_command(data_command[0]),
    .disp_cs(disp_cs[0]), .busy(busy[0]), .fill_done(fill_done[0]), .win_err(win_err[0])
  );

  lcd_window_fill #(.H_RES(320), .V_RES(480), .PIX_MODE(1)) u_dut666 (
    .clk(clk), .reset_states(reset_states), .start(start),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color), .bus_ready(bus_ready),
    .data_out(data_out[1]), .data_valid(data_valid[1]), .data_command(data_command[1]),
    .disp_cs(disp_cs[1]), .busy(busy[1]), .fill_done(fill_done[1]), .win_err(win_err[1])
  );

  // Monitor: sampled on the falling edge, so valid&ready here means the byte
  // transfers on the next rising edge.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (prev_stall[k]) begin
        stall_checks++;
        if (!(data_valid[k] && {data_command[k], data_out[k]} == prev_byte[k])) stall_bad++;
      end
      prev_stall[k] = !reset_states && data_valid[k] && !bus_ready;
      prev_byte[k]  = {data_command[k], data_out[k]};
      if (data_valid[k] && bus_ready) begin
        cap_q[k].push_back({data_command[k], data_out[k]});
        if (!disp_cs[k]) csx_cnt[k]++;
      end
      if (!disp_cs[k]) cslow_cnt[k]++;
      if (fill_done[k]) done_cnt[k]++;
      if (win_err[k]) err_cnt[k]++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_test();
    for (int k = 0; k < 2; k++) begin
      cap_base[k]   = cap_q[k].size();
      done_base[k]  = done_cnt[k];
      err_base[k]   = err_cnt[k];
      csx_base[k]   = csx_cnt[k];
      cslow_base[k] = cslow_cnt[k];
      exp_q[k].delete();
    end
  endtask

  // Expected byte list for a window fill; {data_command, byte}. Stops once lim bytes exist.
  task automatic model(input int ax0, input int ax1, input int ay0, input int ay1,
                       input int c, input int lim);
    int npix;
    npix = (ax1 - ax0 + 1) * (ay1 - ay0 + 1);
    for (int k = 0; k < 2; k++) begin
      exp_q[k].delete();
      exp_q[k].push_back({1'b0, 8'h2A});
      exp_q[k].push_back({1'b1, 8'(ax0 / 256)});
      exp_q[k].push_back({1'b1, 8'(ax0 % 256)});
      exp_q[k].push_back({1'b1, 8'(ax1 / 256)});
      exp_q[k].push_back({1'b1, 8'(ax1 % 256)});
      exp_q[k].push_back({1'b0, 8'h2B});
      exp_q[k].push_back({1'b1, 8'(ay0 / 256)});
      exp_q[k].push_back({1'b1, 8'(ay0 % 256)});
      exp_q[k].push_back({1'b1, 8'(ay1 / 256)});
      exp_q[k].push_back({1'b1, 8'(ay1 % 256)});
      exp_q[k].push_back({1'b0, 8'h2C});
      for (int p = 0; p < npix && exp_q[k].size() < lim; p++) begin
        if (k == 0) begin
          exp_q[k].push_back({1'b1, 8'(c / 256)});
          exp_q[k].push_back({1'b1, 8'(c % 256)});
        end else begin
          exp_q[k].push_back({1'b1, 8'((c / 2048) * 8)});
          exp_q[k].push_back({1'b1, 8'(((c / 32) % 64) * 4)});
          exp_q[k].push_back({1'b1, 8'((c % 32) * 8)});
        end
      end
    end
  endtask

  task automatic check_prefix(input string tag, input int k, input int n);
    int got;
    got = cap_q[k].size() - cap_base[k];
    chk($sformatf("%s_len%0d", tag, k), got, n);
    for (int i = 0; i < n && i < got; i++) begin
      chk($sformatf("%s_byte%0d_%0d", tag, k, i), cap_q[k][cap_base[k] + i], exp_q[k][i]);
      if (cap_q[k][cap_base[k] + i] !== exp_q[k][i]) break;
    end
  endtask

  task automatic do_start(input int ax0, input int ax1, input int ay0, input int ay1,
                          input int c);
    x0 = 10'(ax0);
    x1 = 10'(ax1);
    y0 = 10'(ay0);
    y1 = 10'(ay1);
    color = 16'(c);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_first_byte(input string tag);
    for (int k = 0; k < 2; k++)
      chk($sformatf("%s_first%0d", tag, k),
          {disp_cs[k], data_valid[k], data_command[k], data_out[k]}, {3'b010, 8'h2A});
  endtask

  // Runs a started fill to completion for both instances and checks it.
  task automatic run_fill(input string tag, input bit stalls, input bit pulses, input int budget);
    int done_at [2];
    int busy_bad, c, b0;
    done_at  = '{-1, -1};
    busy_bad = 0;
    c        = 0;
    b0       = exp_q[0].size();
    while ((done_at[0] < 0 || done_at[1] < 0) && c < budget) begin
      for (int k = 0; k < 2; k++) begin
        if (done_at[k] < 0) begin
          if (fill_done[k]) done_at[k] = c;
          else if (!busy[k]) busy_bad++;
        end
      end
      if (done_at[0] >= 0 && done_at[1] >= 0) break;
      bus_ready = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
      start = pulses && (c < b0) && ($urandom_range(0, 2) == 0);
      if (start) begin
        x0 = 10'($urandom_range(0, 200));
        x1 = 10'($urandom_range(0, 319));
        y0 = 10'($urandom_range(0, 200));
        y1 = 10'($urandom_range(0, 479));
        color = 16'($urandom);
      end
      step();
      c++;
    end
    start = 1'b0;
    bus_ready = 1'b1;
    chk($sformatf("%s_busy_held", tag), busy_bad, 0);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_done_in_budget%0d", tag, k), done_at[k] >= 0, 1);
      if (!stalls) chk($sformatf("%s_latency%0d", tag, k), done_at[k], exp_q[k].size());
    end
    step();
    step();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_done_pulses%0d", tag, k), done_cnt[k] - done_base[k], 1);
      chk($sformatf("%s_no_err%0d", tag, k), err_cnt[k] - err_base[k], 0);
      chk($sformatf("%s_cs_xfers%0d", tag, k), csx_cnt[k] - csx_base[k], exp_q[k].size());
      chk($sformatf("%s_idle%0d", tag, k), {disp_cs[k], busy[k], data_valid[k], fill_done[k]},
          4'b1000);
      check_prefix(tag, k, exp_q[k].size());
    end
  endtask

  int bad [4][4] = '{'{5, 4, 0, 0}, '{0, 320, 0, 0}, '{0, 0, 7, 6}, '{0, 0, 0, 480}};

  initial begin
    int wx, wy, ww, wh, wc;
    reset_states = 1'b1;
    start = 1'b0;
    bus_ready = 1'b1;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0;
    color = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++)
      chk($sformatf("reset_outputs%0d", k),
          {data_out[k], data_valid[k], data_command[k], disp_cs[k], busy[k], fill_done[k],
           win_err[k]}, {8'h00, 6'b001000});
    reset_states = 1'b0;
    step();

    // Two-by-two window, colour 0x1234
    begin_test();
    model(10, 11, 20, 21, 16'h1234, 1 << 30);
    do_start(10, 11, 20, 21, 16'h1234);
    check_first_byte("win2x2");
    run_fill("win2x2", 1'b0, 1'b0, 1000);
    chk("win2x2_cs_xfers_565", csx_cnt[0] - csx_base[0], 19);

    // 3x3 window with random stalls, then random windows with and without stalls
    for (int t = 0; t < 5; t++) begin
      ww = (t == 0) ? 3 : $urandom_range(1, 6);
      wh = (t == 0) ? 3 : $urandom_range(1, 6);
      wx = $urandom_range(0, 320 - ww);
      wy = $urandom_range(0, 480 - wh);
      wc = $urandom_range(0, 65535);
      begin_test();
      model(wx, wx + ww - 1, wy, wy + wh - 1, wc, 1 << 30);
      do_start(wx, wx + ww - 1, wy, wy + wh - 1, wc);
      run_fill($sformatf("rand%0d", t), (t % 2) == 0, 1'b0, 3000);
    end
    chk("stall_stable", stall_bad, 0);
    chk("stalls_seen", stall_checks > 0, 1);

    // Single-pixel window at the far corner
    begin_test();
    model(319, 319, 479, 479, 16'hA5C3, 1 << 30);
    do_start(319, 319, 479, 479, 16'hA5C3);
    run_fill("single_px", 1'b0, 1'b0, 200);

    // Start pulses while busy must be ignored
    begin_test();
    model(100, 103, 200, 203, 16'h07E0, 1 << 30);
    do_start(100, 103, 200, 203, 16'h07E0);
    run_fill("busy_pulses", 1'b0, 1'b1, 1000);

    // Rejected windows
    for (int i = 0; i < 4; i++) begin
      begin_test();
      do_start(bad[i][0], bad[i][1], bad[i][2], bad[i][3], 16'hFFFF);
      for (int k = 0; k < 2; k++)
        chk($sformatf("bad%0d_err_pulse%0d", i, k),
            {win_err[k], busy[k], disp_cs[k], data_valid[k]}, 4'b1010);
      step();
      for (int k = 0; k < 2; k++) chk($sformatf("bad%0d_err_clear%0d", i, k), win_err[k], 0);
      repeat (3) step();
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("bad%0d_no_bytes%0d", i, k), cap_q[k].size() - cap_base[k], 0);
        chk($sformatf("bad%0d_cs_high%0d", i, k), cslow_cnt[k] - cslow_base[k], 0);
        chk($sformatf("bad%0d_err_count%0d", i, k), err_cnt[k] - err_base[k], 1);
      end
    end

    // Full-screen fill, red, aborted by reset during pixel 100 of the RGB666 stream
    begin_test();
    model(0, 319, 0, 479, 16'hF800, 400);
    do_start(0, 319, 0, 479, 16'hF800);
    repeat (312) step();
    #1 reset_states = 1'b1;
    #1;
    for (int k = 0; k < 2; k++)
      chk($sformatf("reset_async%0d", k), {disp_cs[k], data_valid[k]}, 2'b10);
    step();
    step();
    for (int k = 0; k < 2; k++) begin
      check_prefix("fullscreen", k, 312);
      chk($sformatf("reset_busy%0d", k), busy[k], 0);
    end
    reset_states = 1'b0;
    step();
    step();
    for (int k = 0; k < 2; k++)
      chk($sformatf("reset_no_done%0d", k), done_cnt[k] - done_base[k], 0);

    // Fresh fill after the abort starts again from CASET
    begin_test();
    model(40, 42, 60, 61, 16'h001F, 1 << 30);
    do_start(40, 42, 60, 61, 16'h001F);
    check_first_byte("after_reset");
    run_fill("after_reset", 1'b0, 1'b0, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
